// File: rtl/one_hot_pkg.sv
// Shared types and helpers for the one-hot detector slice.
package one_hot_pkg;

  localparam int OH_MAX_WIDTH = 64;

  typedef enum logic [1:0] {OH_NONE, OH_ZERO, OH_ONE, OH_MULTI} oh_class_e;

  function automatic int idx_w(input int w);
    int r;
    r = $clog2(w);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/oh_priority_encoder.sv
// Combinational priority encoder: index of the highest set bit and a non-zero flag.
module oh_priority_encoder
  import one_hot_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = vec[i] ? IDX_W'(i) : idx;
    end
  end

  assign any = |vec;

endmodule

// File: rtl/one_hot_detector_chk.sv
// Consistency checker: the one-hot flag must agree with the registered population count.
module one_hot_detector_chk #(
  parameter int IDX_W = 3
) (
  input logic             is_one_hot,
  input logic [IDX_W:0]   bit_count
);

  always_comb begin : p_chk
    assert (is_one_hot == (bit_count == (IDX_W+1)'(1)))
      else $error("one_hot_detector: is_one_hot disagrees with bit_count");
  end

endmodule

// File: rtl/one_hot_detector.sv
// Registered one-hot / zero / multi-hot classifier with highest-bit index.
// Define ONE_HOT_DETECTOR_POPCOUNT_EN to add the registered bit_count output.
module one_hot_detector
  import one_hot_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  output logic             is_one_hot,
  output logic             is_zero,
  output logic             multi_hot,
  output logic [IDX_W-1:0] index
`ifdef ONE_HOT_DETECTOR_POPCOUNT_EN
  ,
  output logic [IDX_W:0]   bit_count
`endif
);

  localparam logic [WIDTH-1:0] ONE_VEC = {{(WIDTH-1){1'b0}}, 1'b1};

  if (WIDTH < 2 || WIDTH > OH_MAX_WIDTH) begin : g_bad_width
    $error("one_hot_detector: WIDTH %0d outside 2..%0d", WIDTH, OH_MAX_WIDTH);
  end

  logic [IDX_W-1:0] idx_s;
  logic             any_s;
  oh_class_e        class_s;

  logic             out_valid_q, out_valid_d;
  logic             is_one_hot_q, is_one_hot_d;
  logic             is_zero_q, is_zero_d;
  logic             multi_hot_q, multi_hot_d;
  logic [IDX_W-1:0] index_q, index_d;

  oh_priority_encoder #(.WIDTH(WIDTH)) u_enc (
    .vec (data_in),
    .idx (idx_s),
    .any (any_s)
  );

  // One-hot iff the sample equals a lone bit at the highest set position.
  always_comb begin
    if (!any_s) begin
      class_s = OH_ZERO;
    end else if (data_in == (ONE_VEC << idx_s)) begin
      class_s = OH_ONE;
    end else begin
      class_s = OH_MULTI;
    end
  end

`ifdef ONE_HOT_DETECTOR_POPCOUNT_EN
  logic [IDX_W:0] pop_s;
  logic [IDX_W:0] bit_count_q, bit_count_d;

  // Population count of the incoming sample.
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_s = pop_s + (IDX_W+1)'(data_in[i]);
    end
  end

  // Result fields update only on an accepted sample.
  always_comb begin
    bit_count_d = in_valid ? pop_s : bit_count_q;
  end

  // Population count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_count_q <= '0;
    end else begin
      bit_count_q <= bit_count_d;
    end
  end

  assign bit_count = bit_count_q;

  one_hot_detector_chk #(.IDX_W(IDX_W)) u_chk (
    .is_one_hot (is_one_hot_q),
    .bit_count  (bit_count_q)
  );
`endif

  // Next-state for the result registers; flags hold while in_valid is low.
  always_comb begin
    out_valid_d  = in_valid;
    is_one_hot_d = is_one_hot_q;
    is_zero_d    = is_zero_q;
    multi_hot_d  = multi_hot_q;
    index_d      = index_q;
    if (in_valid) begin
      index_d = idx_s;
      case (class_s)
        OH_ZERO: begin
          is_one_hot_d = 1'b0; is_zero_d = 1'b1; multi_hot_d = 1'b0;
        end
        OH_ONE: begin
          is_one_hot_d = 1'b1; is_zero_d = 1'b0; multi_hot_d = 1'b0;
        end
        OH_MULTI: begin
          is_one_hot_d = 1'b0; is_zero_d = 1'b0; multi_hot_d = 1'b1;
        end
        default: begin
          is_one_hot_d = 1'b0; is_zero_d = 1'b0; multi_hot_d = 1'b0;
        end
      endcase
    end else begin
      index_d = index_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      is_one_hot_q <= 1'b0;
      is_zero_q    <= 1'b0;
      multi_hot_q  <= 1'b0;
      index_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      is_one_hot_q <= is_one_hot_d;
      is_zero_q    <= is_zero_d;
      multi_hot_q  <= multi_hot_d;
      index_q      <= index_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign is_one_hot = is_one_hot_q;
  assign is_zero    = is_zero_q;
  assign multi_hot  = multi_hot_q;
  assign index      = index_q;

endmodule

// File: tb/tb_one_hot_detector.sv
// Scoreboard bench for one_hot_detector at WIDTH 8, 2 and 64 against a popcount reference model.
module tb_one_hot_detector;

  typedef struct packed {
    logic       vld;
    logic       oh;
    logic       z;
    logic       mh;
    logic [6:0] idx;
    logic [7:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  d8;
  logic [1:0]  d2;
  logic [63:0] d64;

  logic       v8, oh8, z8, mh8;
  logic [2:0] i8;
  logic       v2, oh2, z2, mh2;
  logic [0:0] i2;
  logic       v64, oh64, z64, mh64;
  logic [5:0] i64;
  logic [3:0] bc8;
  logic [1:0] bc2;
  logic [6:0] bc64;

  int n_vec = 0;
  int n_err = 0;
  exp_t q8[$], q2[$], q64[$];
  exp_t last8, last2, last64;

  always #5 clk = ~clk;

  one_hot_detector #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(d8),
    .out_valid(v8), .is_one_hot(oh8), .is_zero(z8), .multi_hot(mh8), .index(i8)
`ifdef ONE_HOT_DETECTOR_POPCOUNT_EN
    , .bit_count(bc8)
`endif
  );

  one_hot_detector #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(d2),
    .out_valid(v2), .is_one_hot(oh2), .is_zero(z2), .multi_hot(mh2), .index(i2)
`ifdef ONE_HOT_DETECTOR_POPCOUNT_EN
    , .bit_count(bc2)
`endif
  );

  one_hot_detector #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(d64),
    .out_valid(v64), .is_one_hot(oh64), .is_zero(z64), .multi_hot(mh64), .index(i64)
`ifdef ONE_HOT_DETECTOR_POPCOUNT_EN
    , .bit_count(bc64)
`endif
  );

`ifndef ONE_HOT_DETECTOR_POPCOUNT_EN
  assign bc8 = '0;
  assign bc2 = '0;
  assign bc64 = '0;
`endif

  function automatic exp_t model(input logic [63:0] v, input int w);
    exp_t e;
    int   c;
    e = '0;
    c = 0;
    for (int i = 0; i < w; i++) begin
      if (v[i]) begin
        c++;
        e.idx = 7'(i);
      end
    end
    e.vld = 1'b1;
    e.cnt = 8'(c);
    e.z   = (c == 0);
    e.oh  = (c == 1);
    e.mh  = (c > 1);
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic check_one(input string who, input exp_t e, input logic vld, input logic oh,
                           input logic z, input logic mh, input logic [63:0] idx,
                           input logic [63:0] cnt);
    cmp({who, " out_valid"}, 64'(vld), 64'(e.vld));
    cmp({who, " is_one_hot"}, 64'(oh), 64'(e.oh));
    cmp({who, " is_zero"}, 64'(z), 64'(e.z));
    cmp({who, " multi_hot"}, 64'(mh), 64'(e.mh));
    cmp({who, " index"}, idx, 64'(e.idx));
`ifdef ONE_HOT_DETECTOR_POPCOUNT_EN
    cmp({who, " bit_count"}, cnt, 64'(e.cnt));
`endif
  endtask

  task automatic check_all(input exp_t e8, input exp_t e2, input exp_t e64);
    check_one("w8", e8, v8, oh8, z8, mh8, 64'(i8), 64'(bc8));
    check_one("w2", e2, v2, oh2, z2, mh2, 64'(i2), 64'(bc2));
    check_one("w64", e64, v64, oh64, z64, mh64, 64'(i64), 64'(bc64));
  endtask

  // Drive one sample on the falling edge, push expectations, pop and compare after the rising edge.
  task automatic apply(input logic [7:0] a8, input logic [1:0] a2, input logic [63:0] a64);
    @(negedge clk);
    in_valid = 1'b1;
    d8 = a8;
    d2 = a2;
    d64 = a64;
    q8.push_back(model({56'd0, a8}, 8));
    q2.push_back(model({62'd0, a2}, 2));
    q64.push_back(model(a64, 64));
    @(posedge clk);
    #1;
    last8 = q8.pop_front();
    last2 = q2.pop_front();
    last64 = q64.pop_front();
    check_all(last8, last2, last64);
  endtask

  initial begin
    exp_t h8, h2, h64;
    logic [63:0] r64;
    rst_n = 1'b0;
    in_valid = 1'b0;
    d8 = 8'h00;
    d2 = 2'b00;
    d64 = 64'd0;

    repeat (2) @(posedge clk);
    #1;
    check_all('0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all('0, '0, '0);

    apply(8'h10, 2'b01, 64'h0000_0000_0000_0001);
    apply(8'h28, 2'b11, 64'h8000_0000_0000_0000);
    apply(8'h02, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF);
    apply(8'h00, 2'b00, 64'h0000_0000_0000_0000);
    apply(8'h80, 2'b10, 64'h0000_0100_0000_0000);
    apply(8'hFF, 2'b11, 64'h0000_0001_0000_0001);

    // Hold: results stay, out_valid drops.
    @(negedge clk);
    in_valid = 1'b0;
    d8 = 8'h01;
    d2 = 2'b01;
    d64 = 64'd0;
    h8 = last8;
    h2 = last2;
    h64 = last64;
    h8.vld = 1'b0;
    h2.vld = 1'b0;
    h64.vld = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_all(h8, h2, h64);
    end

    // Asynchronous reset between edges clears outputs without a clock edge.
    apply(8'h10, 2'b01, 64'h8000_0000_0000_0000);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_all('0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'h01, 2'b10, 64'h0000_0000_0000_0002);

    for (int i = 0; i < 256; i++) begin
      case (i % 4)
        0: r64 = 64'd1 << $urandom_range(63, 0);
        1: r64 = {$urandom, $urandom};
        2: r64 = (64'd1 << $urandom_range(63, 0)) | (64'd1 << $urandom_range(63, 0));
        default: r64 = {$urandom, $urandom} & {$urandom, $urandom};
      endcase
      apply(8'(i), 2'(i), r64);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
